// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types and constants for the register-file dump engine
// Optional framing build: REGFILE_DUMP_FRAMING_EN
package regfile_dump_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WAIT,
      ST_SEND,
      ST_CKS,
      ST_FIN
   } dump_state_e;

   function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// rtl/dump_byte_serializer.sv - loads up to one 32-bit word and emits it LSB byte first over valid/ready
// load_last_i is the index of the final byte (3 for a full word), so short header/checksum loads reuse it
module dump_byte_serializer
   import regfile_dump_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic [1:0]        load_last_i,
   input  logic              tx_ready_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   output logic              last_o
);

   logic [DATA_W-1:0] shift_q, shift_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        len_q, len_d;
   logic              valid_q, valid_d;
   logic              handshake;

   assign handshake  = valid_q & tx_ready_i;
   assign last_o     = (cnt_q == len_q);
   assign tx_data_o  = shift_q[7:0];
   assign tx_valid_o = valid_q;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      valid_d = valid_q;
      if (load_i) begin
         shift_d = load_data_i;
         cnt_d   = '0;
         len_d   = load_last_i;
         valid_d = 1'b1;
      end else if (handshake) begin
         // Shifting consumed bytes out leaves tx_data at zero once the word is drained.
         shift_d = shift_q >> 8;
         cnt_d   = cnt_q + 2'd1;
         if (last_o) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the register file, streams each word as bytes, halts the core meanwhile
// Optional sync/count header and XOR checksum trailer: REGFILE_DUMP_FRAMING_EN
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int FIRST_REG    = 0,
   parameter int LAST_REG     = 31,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              core_halt_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i
);

   localparam int                WAIT_W    = $clog2(READ_LATENCY + 2);
   localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(READ_LATENCY);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

   if (LAST_REG < FIRST_REG || FIRST_REG < 0 || LAST_REG > 31 || READ_LATENCY < 0) begin : g_bad_params
      $error("regfile_dump: need 0 <= FIRST_REG <= LAST_REG <= 31 and READ_LATENCY >= 0");
   end

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              ser_load;
   logic [DATA_W-1:0] ser_data;
   logic [1:0]        ser_last_idx;
   logic              ser_last;
   logic              ser_done;
   logic [DATA_W-1:0] word;

`ifdef REGFILE_DUMP_FRAMING_EN
   localparam logic [7:0] REG_COUNT = 8'(LAST_REG - FIRST_REG + 1);
   logic [7:0] xor_q, xor_d;
`endif

   // x0 is architecturally zero but the block RAM behind the port does not guarantee it.
   assign word     = (idx_q == '0) ? '0 : rd_data_i;
   assign ser_done = tx_valid_o & tx_ready_i & ser_last;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      wait_d       = wait_q;
      ser_load     = 1'b0;
      ser_data     = '0;
      ser_last_idx = 2'd3;
`ifdef REGFILE_DUMP_FRAMING_EN
      xor_d        = xor_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               idx_d  = FIRST_IDX;
               wait_d = '0;
`ifdef REGFILE_DUMP_FRAMING_EN
               state_d      = ST_HDR;
               ser_load     = 1'b1;
               ser_data     = {16'h0, REG_COUNT, SYNC_BYTE};
               ser_last_idx = 2'd1;
               xor_d        = '0;
`else
               state_d = ST_WAIT;
`endif
            end
         end
`ifdef REGFILE_DUMP_FRAMING_EN
         ST_HDR: begin
            if (ser_done) begin
               state_d = ST_WAIT;
            end
         end
`endif
         ST_WAIT: begin
            if (wait_q == WAIT_END) begin
               ser_load = 1'b1;
               ser_data = word;
               state_d  = ST_SEND;
`ifdef REGFILE_DUMP_FRAMING_EN
               xor_d    = xor_q ^ xor_bytes(word);
`endif
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (ser_done) begin
               if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_FRAMING_EN
                  state_d      = ST_CKS;
                  ser_load     = 1'b1;
                  ser_data     = {24'h0, xor_q};
                  ser_last_idx = 2'd0;
`else
                  state_d = ST_FIN;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  wait_d  = '0;
                  state_d = ST_WAIT;
               end
            end
         end
`ifdef REGFILE_DUMP_FRAMING_EN
         ST_CKS: begin
            if (ser_done) begin
               state_d = ST_FIN;
            end
         end
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
`ifdef REGFILE_DUMP_FRAMING_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
`ifdef REGFILE_DUMP_FRAMING_EN
         xor_q   <= xor_d;
`endif
      end
   end

   assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done_o      = (state_q == ST_FIN);
   assign core_halt_o = busy_o;
   assign rd_addr_o   = idx_q;

   dump_byte_serializer u_ser (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (ser_load),
      .load_data_i (ser_data),
      .load_last_i (ser_last_idx),
      .tx_ready_i  (tx_ready_i),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .last_o      (ser_last)
   );

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed and randomized checks of regfile_dump against a byte-list model
module tb_regfile_dump;

`ifdef REGFILE_DUMP_FRAMING_EN
   localparam bit FRAMING = 1'b1;
   localparam int B_FIRST = 1;
   localparam int B_LAST  = 2;
`else
   localparam bit FRAMING = 1'b0;
   localparam int B_FIRST = 5;
   localparam int B_LAST  = 5;
`endif
   localparam int HDR       = FRAMING ? 2 : 0;
   localparam int FIRST_LAT = FRAMING ? 1 : 3;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        start     [2];
   logic        busy      [2];
   logic        done      [2];
   logic        halt      [2];
   logic [4:0]  rd_addr   [2];
   logic [31:0] rd_data   [2];
   logic [7:0]  tx_data   [2];
   logic        tx_valid  [2];
   logic        tx_ready  [2];
   logic [31:0] rf        [2][32];

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] lit_q[$];
   bit         ab;

   always #5 clk = ~clk;

   regfile_dump u_dut0 (
      .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
      .core_halt_o(halt[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
      .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .tx_ready_i(tx_ready[0])
   );

   regfile_dump #(.FIRST_REG(B_FIRST), .LAST_REG(B_LAST), .READ_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
      .core_halt_o(halt[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
      .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .tx_ready_i(tx_ready[1])
   );

   // Registered block-RAM read port, one cycle of latency.
   always @(posedge clk) begin
      rd_data[0] <= rf[0][rd_addr[0]];
      rd_data[1] <= rf[1][rd_addr[1]];
   end

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic build_exp(input int d, input int first, input int last);
      logic [7:0]  x;
      logic [31:0] w;
      exp_q.delete();
      x = 8'h00;
      if (FRAMING) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'(last - first + 1));
      end
      for (int r = first; r <= last; r++) begin
         w = (r == 0) ? 32'h0 : rf[d][r];
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            x ^= w[8*b +: 8];
         end
      end
      if (FRAMING) exp_q.push_back(x);
   endtask

   task automatic run_dump(input int d, input int first, input int last, input bit rnd_ready,
                           input int mid_start_at, input bit start_at_done, input int abort_after,
                           output bit aborted);
      int         cyc;
      int         first_valid;
      bit         fin;
      bit         prev_stall;
      logic [7:0] prev_data;
      build_exp(d, first, last);
      got_q.delete();
      cyc = 0; first_valid = -1; fin = 0; prev_stall = 0; prev_data = 8'h00; aborted = 0;
      @(negedge clk);
      start[d]    = 1'b1;
      tx_ready[d] = 1'b1;
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start[d]    = (cyc == mid_start_at);
         tx_ready[d] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (cyc == 1) chk("rd_addr_first", 32'(rd_addr[d]), first);
         if (prev_stall) begin
            chk("hold_valid", 32'(tx_valid[d]), 1);
            chk("hold_data", 32'(tx_data[d]), 32'(prev_data));
         end
         if (tx_valid[d] && first_valid < 0) first_valid = cyc;
         if (done[d]) begin
            fin = 1;
            chk("busy_at_done", 32'(busy[d]), 0);
            chk("halt_at_done", 32'(halt[d]), 0);
            if (start_at_done) start[d] = 1'b1;
         end else begin
            chk("busy_in_dump", 32'(busy[d]), 1);
            chk("halt_in_dump", 32'(halt[d]), 1);
         end
         if (tx_valid[d] && tx_ready[d]) got_q.push_back(tx_data[d]);
         prev_stall = tx_valid[d] && !tx_ready[d];
         prev_data  = tx_data[d];
         if (abort_after > 0 && got_q.size() == abort_after) begin
            aborted = 1;
            break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         rst[d]   = 1'b1;
         start[d] = 1'b0;
         @(negedge clk);
         #1;
         chk("abort_valid", 32'(tx_valid[d]), 0);
         chk("abort_busy", 32'(busy[d]), 0);
         chk("abort_halt", 32'(halt[d]), 0);
         chk("abort_data", 32'(tx_data[d]), 0);
         rst[d] = 1'b0;
      end else begin
         chk("done_seen", 32'(fin), 1);
         chk("first_valid_lat", first_valid, FIRST_LAT);
         chk("byte_count", got_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
         end
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start[d] = 1'b0;
            #1;
            chk("idle_after_done", {29'h0, tx_valid[d], busy[d], done[d]}, 0);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; tx_ready[d] = 1'b1;
         for (int r = 0; r < 32; r++) rf[d][r] = $urandom;
         rf[d][0] = 32'hFFFFFFFF;
      end
      rf[0][1]  = 32'h11223344;
      rf[0][31] = 32'hDEADBEEF;
      rf[1][1]  = 32'h01020304;
      rf[1][2]  = 32'h000000FF;
      rf[1][5]  = 32'hCAFEF00D;

      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 32'(busy[d]), 0);
         chk("rst_done", 32'(done[d]), 0);
         chk("rst_halt", 32'(halt[d]), 0);
         chk("rst_rd_addr", 32'(rd_addr[d]), 0);
         chk("rst_tx_data", 32'(tx_data[d]), 0);
         chk("rst_tx_valid", 32'(tx_valid[d]), 0);
      end

      // Full dump, no backpressure.
      run_dump(0, 0, 31, 1'b0, 0, 1'b0, 0, ab);
      chk("total_bytes", got_q.size(), FRAMING ? 131 : 128);
      if (got_q.size() >= HDR + 128) begin
         chk("x0_b0", 32'(got_q[HDR+0]), 32'h00);
         chk("x0_b3", 32'(got_q[HDR+3]), 32'h00);
         chk("x1_b0", 32'(got_q[HDR+4]), 32'h44);
         chk("x1_b3", 32'(got_q[HDR+7]), 32'h11);
         chk("x31_b0", 32'(got_q[HDR+124]), 32'hEF);
         chk("x31_b3", 32'(got_q[HDR+127]), 32'hDE);
      end

      // Random backpressure, same register contents.
      run_dump(0, 0, 31, 1'b1, 0, 1'b0, 0, ab);

      // Narrow range on the second instance.
      run_dump(1, B_FIRST, B_LAST, 1'b0, 0, 1'b0, 0, ab);
`ifdef REGFILE_DUMP_FRAMING_EN
      lit_q = '{8'hA5, 8'h02, 8'h04, 8'h03, 8'h02, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFB};
`else
      lit_q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
`endif
      chk("narrow_count", got_q.size(), lit_q.size());
      for (int i = 0; i < lit_q.size(); i++) begin
         if (i < got_q.size()) chk($sformatf("narrow%0d", i), 32'(got_q[i]), 32'(lit_q[i]));
      end

      // Start pulses mid-dump and in the done cycle must be ignored.
      for (int r = 2; r < 31; r++) rf[0][r] = $urandom;
      run_dump(0, 0, 31, 1'b1, 20, 1'b1, 0, ab);

      // Reset after 10 bytes, then a fresh dump from FIRST_REG.
      run_dump(0, 0, 31, 1'b0, 0, 1'b0, 10, ab);
      chk("aborted", 32'(ab), 1);
      run_dump(0, 0, 31, 1'b0, 0, 1'b0, 0, ab);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
